pio_clk_init_sequencer: RTL and testbench
=========================================

Name: pio_clk_init_sequencer

Overview:
- Consumes the single-bit "clock init" level driven by the Nios PIO output port.
- Releases the external converter/sensor front-end from reset and starts a glitch-free divided device clock.
- Waits a settle interval, then emits periodic one-cycle sample strobes and counts them for the levitation control loop.
- Shuts the clock down cleanly when the init bit is cleared.

Parameters:
- DIV_WIDTH, 16, width of the clock-divide ratio input and phase counter.
- SETTLE_CYCLES, 256, minimum clk cycles spent in SETTLE before sampling may start (must be >= 1).
- CNT_WIDTH, 32, width of the sample counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- init_in  in  1  init level from PIO out_port; 1 = run, 0 = stop.
- div_in  in  DIV_WIDTH  device-clock period in clk cycles; latched on SETTLE entry.
- dev_rst  out  1  active-high reset to the external device.
- clk_out  out  1  divided device clock, registered.
- sample_stb  out  1  one-cycle sample pulse.
- sample_count  out  CNT_WIDTH  strobes issued since last start, saturating.
- state_o  out  2  FSM state: IDLE=0, SETTLE=1, RUN=2, STOPPING=3.
- running  out  1  high iff state is RUN.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state IDLE, dev_rst=1, clk_out=0, sample_stb=0, sample_count=0.
  - running=0, state_o=0, phase=0, settle_cnt=0, div_lat=2, init_q=0.
- Input registration: init_in is registered once into init_q. All FSM decisions use init_q, so one cycle of input latency.
- IDLE:
  - dev_rst=1, clk_out=0, no strobes.
  - When init_q=1: go to SETTLE, latch div_lat = max(div_in, 2), clear phase, settle_cnt and sample_count.
- Phase counter (all non-IDLE states): counts 0..div_lat-1 and wraps to 0.
  - clk_out is high in cycles where phase < div_lat>>1, low otherwise. Example: div 4 gives 2 high/2 low; div 5 gives 2 high/3 low.
- SETTLE:
  - dev_rst=0, clk_out toggling, no strobes, settle_cnt increments each cycle.
  - If settle_cnt >= SETTLE_CYCLES-1 and phase = div_lat-1: go to RUN. The transition happens only at a period boundary.
  - If init_q=0: go to IDLE immediately; clk_out forced 0 the next cycle.
- RUN:
  - dev_rst=0.
  - sample_stb=1 in every cycle where phase = div_lat-1; sample_count increments by 1 the following cycle.
  - sample_count saturates at all-ones.
  - If init_q=0: go to STOPPING.
- STOPPING:
  - Clock and strobes continue until phase = div_lat-1. That cycle emits its strobe, completing the period.
  - Next state is IDLE, where clk_out=0 and dev_rst=1.
  - init_q returning to 1 in STOPPING is ignored until IDLE, then restarts normally. IDLE is level-sensitive, so no start request is lost.
- Divide ratio: div_in changes outside SETTLE entry have no effect until the next start.
- Glitch-free guarantee: clk_out never produces a high or low pulse shorter than floor(div_lat/2) clk cycles, except the reset-forced low.

Decomposition:
- Shared package holds:
  - state enum (IDLE/SETTLE/RUN/STOPPING with the encodings above).
  - minimum divide constant (2).
  - state_o width.
- One sub-module, clk_div_phase, holds:
  - phase counter, div_lat latch and clamp.
  - clk_out generation and wrap flag.
- The top level holds the FSM, settle counter, strobe and sample counter.

Test Plan:
- Reset check: assert reset mid-RUN with div_in=4 -> within the same cycle dev_rst=1, clk_out=0, sample_stb=0, sample_count=0, state_o=0; after release, state stays IDLE while init_in=0.
- Start-up timing: SETTLE_CYCLES=8, div_in=4, raise init_in.
  - State is SETTLE 2 clk edges after init_in rises.
  - dev_rst=0 from then on; clk_out pattern 1,1,0,0 repeating.
  - RUN after 8 SETTLE cycles; first sample_stb 4 cycles later (12 cycles after SETTLE entry).
  - Strobes repeat every 4 cycles; sample_count=3 after the 3rd strobe.
- Clean stop: with div_in=5, drop init_in mid-period at phase 1 -> STOPPING; a strobe is still emitted at phase 4; then IDLE with clk_out=0, dev_rst=1; no high pulse on clk_out shorter than 2 cycles.
- Clamp: div_in=0 and div_in=1 -> behaves as div 2: clk_out alternates 1,0 and sample_stb fires every 2 cycles in RUN.
- Abort in SETTLE: drop init_in 3 cycles into SETTLE -> IDLE, no strobe ever, sample_count=0; re-raising init_in restarts the full 8-cycle settle and re-latches div_in.
- Saturation and restart: CNT_WIDTH=4, div 2, run for 20 strobes -> sample_count holds 15; stop and restart -> sample_count clears to 0 on SETTLE entry.

Source files
------------

// File: rtl/pio_clk_init_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pio_clk_init_sequencer_pkg
//
// Shared definitions for the PIO-driven clock init sequencer:
//   - state_e   : sequencer FSM state with the encodings visible on state_o
//   - STATE_W   : width of the state_o port
//   - MIN_DIV   : smallest usable device-clock divide ratio; anything below
//                 this cannot produce both a high and a low phase
// ---------------------------------------------------------------------------
package pio_clk_init_sequencer_pkg;

  localparam int STATE_W = 2;
  localparam int MIN_DIV = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_RUN      = 2'd2,
    ST_STOPPING = 2'd3
  } state_e;

endpackage

// File: rtl/pio_clk_init_sequencer_clk_div_phase.sv
// ---------------------------------------------------------------------------
// clk_div_phase
//
// Phase counter and divided-clock generator for the device clock.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   load        in   start of a new session: latch the clamped ratio, phase 0
//   active_next in   sequencer will be outside IDLE next cycle
//   div_in      in   requested device-clock period in clk cycles
//   wrap        out  current cycle is the last of a device-clock period
//   wrap_next   out  next cycle will be the last of a device-clock period
//   clk_out     out  registered divided clock
//
// clk_out is registered but must line up with the phase of the cycle it is
// shown in, so it is computed from the next phase and next ratio. The same
// look-ahead is exported as wrap_next so the parent can register its strobe.
// ---------------------------------------------------------------------------
module clk_div_phase
  import pio_clk_init_sequencer_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 active_next,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic                 wrap,
  output logic                 wrap_next,
  output logic                 clk_out
);

  localparam logic [DIV_WIDTH-1:0] MIN_DIV_W = DIV_WIDTH'(MIN_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE_W     = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] phase_q, phase_d;
  logic [DIV_WIDTH-1:0] div_lat_q, div_lat_d;
  logic                 clk_out_q, clk_out_d;

  // Ratio latch: only a new session picks up div_in, and ratios below the
  // minimum are clamped so the clock always has a high and a low phase.
  always_comb begin
    div_lat_d = div_lat_q;
    if (load) begin
      div_lat_d = (div_in < MIN_DIV_W) ? MIN_DIV_W : div_in;
    end
  end

  assign wrap = (phase_q == div_lat_q - ONE_W);

  // Phase advance: rests at zero whenever the sequencer is idle and restarts
  // from zero on a new session, otherwise counts 0..div_lat-1 and wraps.
  always_comb begin
    phase_d = '0;
    if (active_next && !load) begin
      phase_d = wrap ? '0 : phase_q + ONE_W;
    end
  end

  // Look-ahead outputs: high for the first half of each period (the shorter
  // half for odd ratios), forced low while idle.
  always_comb begin
    wrap_next = (phase_d == div_lat_d - ONE_W);
    clk_out_d = active_next && (phase_d < (div_lat_d >> 1));
  end

  // Phase, ratio and clock registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= '0;
      div_lat_q <= MIN_DIV_W;
      clk_out_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      div_lat_q <= div_lat_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

endmodule

// File: rtl/pio_clk_init_sequencer.sv
// ---------------------------------------------------------------------------
// pio_clk_init_sequencer
//
// Turns the Nios PIO "clock init" level into a clean power-up sequence for
// the external converter/sensor front-end: release its reset, run a divided
// device clock, wait a settle interval, then issue periodic sample strobes
// and count them. Clearing the init level finishes the current clock period
// before the device is put back into reset.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   init_in       in   PIO init level, 1 = run, 0 = stop
//   div_in        in   device-clock period in clk cycles (latched on start)
//   dev_rst       out  active-high reset to the external device
//   clk_out       out  registered divided device clock
//   sample_stb    out  one-cycle sample strobe, last cycle of each period
//   sample_count  out  strobes issued since the last start, saturating
//   state_o       out  FSM state: IDLE=0, SETTLE=1, RUN=2, STOPPING=3
//   running       out  high while in RUN
// ---------------------------------------------------------------------------
module pio_clk_init_sequencer
  import pio_clk_init_sequencer_pkg::*;
#(
  parameter int DIV_WIDTH     = 16,
  parameter int SETTLE_CYCLES = 256,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init_in,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic                 dev_rst,
  output logic                 clk_out,
  output logic                 sample_stb,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic [STATE_W-1:0]   state_o,
  output logic                 running
);

  // The settle counter only needs to reach SETTLE_CYCLES-1; it saturates
  // there so a long first period cannot wrap it back below the threshold.
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  logic                 init_q;
  state_e               state_q, state_d;
  logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic                 sample_stb_q, sample_stb_d;
  logic [CNT_WIDTH-1:0] sample_count_q, sample_count_d;
  logic                 dev_rst_q, dev_rst_d;
  logic                 running_q, running_d;

  logic load;
  logic active_next;
  logic wrap;
  logic wrap_next;

  clk_div_phase #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clk_div_phase (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .active_next (active_next),
    .div_in      (div_in),
    .wrap        (wrap),
    .wrap_next   (wrap_next),
    .clk_out     (clk_out)
  );

  // Next-state logic. SETTLE only hands over to RUN on a period boundary so
  // the first RUN period is a whole one; an abort in SETTLE wins over that.
  // STOPPING ignores init_q and always drains to the end of its period.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_q) begin
          state_d = ST_SETTLE;
          load    = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!init_q) begin
          state_d = ST_IDLE;
        end else if ((settle_cnt_q == SETTLE_LAST) && wrap) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!init_q) begin
          state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (wrap) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign active_next = (state_d != ST_IDLE);

  // Settle timer, strobe and sample counter. The strobe is registered from
  // the divider's look-ahead so it lands on the last cycle of each period;
  // the counter then picks it up one cycle later and sticks at all-ones.
  always_comb begin
    settle_cnt_d   = settle_cnt_q;
    sample_count_d = sample_count_q;
    if (load) begin
      settle_cnt_d = '0;
    end else if ((state_q == ST_SETTLE) && (settle_cnt_q != SETTLE_LAST)) begin
      settle_cnt_d = settle_cnt_q + SETTLE_ONE;
    end
    if (load) begin
      sample_count_d = '0;
    end else if (sample_stb_q && (sample_count_q != '1)) begin
      sample_count_d = sample_count_q + CNT_ONE;
    end
    sample_stb_d = ((state_d == ST_RUN) || (state_d == ST_STOPPING)) && wrap_next;
    dev_rst_d    = (state_d == ST_IDLE);
    running_d    = (state_d == ST_RUN);
  end

  // Single state/output register bank; init_in gets exactly one stage of
  // registration and every decision above uses that registered copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_q         <= 1'b0;
      state_q        <= ST_IDLE;
      settle_cnt_q   <= '0;
      sample_stb_q   <= 1'b0;
      sample_count_q <= '0;
      dev_rst_q      <= 1'b1;
      running_q      <= 1'b0;
    end else begin
      init_q         <= init_in;
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      sample_stb_q   <= sample_stb_d;
      sample_count_q <= sample_count_d;
      dev_rst_q      <= dev_rst_d;
      running_q      <= running_d;
    end
  end

  assign dev_rst      = dev_rst_q;
  assign sample_stb   = sample_stb_q;
  assign sample_count = sample_count_q;
  assign state_o      = state_q;
  assign running      = running_q;

endmodule

// File: tb/tb_pio_clk_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pio_clk_init_sequencer
//
// Bench for pio_clk_init_sequencer with SETTLE_CYCLES=8 and CNT_WIDTH=4.
// A reference model tracks the session as "cycles since SETTLE entry" and
// derives phase, clock level, RUN start and strobes arithmetically from it.
// ---------------------------------------------------------------------------
module tb_pio_clk_init_sequencer;

  localparam int DIV_WIDTH     = 16;
  localparam int SETTLE_CYCLES = 8;
  localparam int CNT_WIDTH     = 4;
  localparam int CNT_MAX       = (1 << CNT_WIDTH) - 1;
  localparam int NUM_VECS      = 22;

  logic                 clk;
  logic                 reset;
  logic                 init_in;
  logic [DIV_WIDTH-1:0] div_in;
  logic                 dev_rst;
  logic                 clk_out;
  logic                 sample_stb;
  logic [CNT_WIDTH-1:0] sample_count;
  logic [1:0]           state_o;
  logic                 running;

  int checks;
  int errors;

  // Reference model: session active flag, registered init copy, cycle index
  // within the session, latched ratio, stop cycle (-1 if not stopping), count.
  int mActive, mInitQ, mT, mDiv, mStopT, mCount;

  int cycleNo, curHigh, minHigh, stbCount, stbInStop;

  typedef struct {
    int init;
    int div;
    int state;
    int devRst;
    int clkOut;
    int stb;
    int count;
  } vec_t;

  vec_t vecs [NUM_VECS];

  pio_clk_init_sequencer #(
    .DIV_WIDTH     (DIV_WIDTH),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .init_in      (init_in),
    .div_in       (div_in),
    .dev_rst      (dev_rst),
    .clk_out      (clk_out),
    .sample_stb   (sample_stb),
    .sample_count (sample_count),
    .state_o      (state_o),
    .running      (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // First session cycle index at which RUN begins: the first period boundary
  // at or after SETTLE_CYCLES.
  function automatic int runStart(int d);
    return ((SETTLE_CYCLES + d - 1) / d) * d;
  endfunction

  function automatic int modelState();
    if (mActive == 0) return 0;
    if (mT < runStart(mDiv)) return 1;
    if (mStopT < 0) return 2;
    return 3;
  endfunction

  task automatic modelReset();
    mActive = 0;
    mInitQ  = 0;
    mT      = 0;
    mDiv    = 2;
    mStopT  = -1;
    mCount  = 0;
    curHigh = 0;
  endtask

  // Advance the model across one clock edge using the inputs held at it.
  task automatic modelStep();
    int ph;
    int rs;
    if (mActive == 0) begin
      if (mInitQ != 0) begin
        mActive = 1;
        mT      = 0;
        mDiv    = (int'(div_in) < 2) ? 2 : int'(div_in);
        mStopT  = -1;
        mCount  = 0;
      end
    end else begin
      rs = runStart(mDiv);
      ph = mT % mDiv;
      if (mT < rs) begin
        if (mInitQ == 0) mActive = 0;
        else mT++;
      end else begin
        if ((ph == mDiv - 1) && (mCount < CNT_MAX)) mCount++;
        if (mStopT < 0) begin
          if (mInitQ == 0) mStopT = (ph == mDiv - 1) ? mT + mDiv : mT + (mDiv - 1 - ph);
          mT++;
        end else if (mT == mStopT) begin
          mActive = 0;
        end else begin
          mT++;
        end
      end
    end
    mInitQ = init_in ? 1 : 0;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(int init, int d);
    init_in = (init != 0);
    div_in  = DIV_WIDTH'(d);
  endtask

  task automatic compareModel();
    int st;
    st = modelState();
    checkOutput("model_state", 32'(state_o), st);
    checkOutput("model_dev_rst", 32'(dev_rst), (mActive == 0) ? 1 : 0);
    checkOutput("model_clk_out", 32'(clk_out),
                ((mActive != 0) && ((mT % mDiv) < mDiv / 2)) ? 1 : 0);
    checkOutput("model_stb", 32'(sample_stb),
                ((mActive != 0) && (mT >= runStart(mDiv)) && ((mT % mDiv) == mDiv - 1)) ? 1 : 0);
    checkOutput("model_count", 32'(sample_count), mCount);
    checkOutput("model_running", 32'(running), (st == 2) ? 1 : 0);
  endtask

  // One clock: model follows the edge, outputs are compared at the falling
  // edge, and pulse/strobe statistics are gathered for the directed checks.
  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    cycleNo++;
    compareModel();
    if (clk_out) begin
      curHigh++;
    end else begin
      if ((curHigh > 0) && (curHigh < minHigh)) minHigh = curHigh;
      curHigh = 0;
    end
    if (sample_stb) begin
      stbCount++;
      if (state_o == 2'd3) stbInStop++;
    end
  endtask

  task automatic waitState(int target, int budget, string name);
    int n;
    n = 0;
    while ((32'(state_o) != target) && (n < budget)) begin
      stepCycle();
      n++;
    end
    checkOutput(name, 32'(state_o), target);
  endtask

  initial begin
    int lastStb;
    int settleLen;
    int n;
    int b;
    int hold;
    checks    = 0;
    errors    = 0;
    cycleNo   = 0;
    minHigh   = 1000;
    stbCount  = 0;
    stbInStop = 0;
    modelReset();

    // Start-up with div 4: one row per clock after raising init_in.
    vecs[0]  = '{1, 4, 0, 1, 0, 0, 0};
    vecs[1]  = '{1, 4, 1, 0, 1, 0, 0};
    vecs[2]  = '{1, 4, 1, 0, 1, 0, 0};
    vecs[3]  = '{1, 4, 1, 0, 0, 0, 0};
    vecs[4]  = '{1, 4, 1, 0, 0, 0, 0};
    vecs[5]  = '{1, 4, 1, 0, 1, 0, 0};
    vecs[6]  = '{1, 4, 1, 0, 1, 0, 0};
    vecs[7]  = '{1, 4, 1, 0, 0, 0, 0};
    vecs[8]  = '{1, 4, 1, 0, 0, 0, 0};
    vecs[9]  = '{1, 4, 2, 0, 1, 0, 0};
    vecs[10] = '{1, 4, 2, 0, 1, 0, 0};
    vecs[11] = '{1, 4, 2, 0, 0, 0, 0};
    vecs[12] = '{1, 4, 2, 0, 0, 1, 0};
    vecs[13] = '{1, 4, 2, 0, 1, 0, 1};
    vecs[14] = '{1, 4, 2, 0, 1, 0, 1};
    vecs[15] = '{1, 4, 2, 0, 0, 0, 1};
    vecs[16] = '{1, 4, 2, 0, 0, 1, 1};
    vecs[17] = '{1, 4, 2, 0, 1, 0, 2};
    vecs[18] = '{1, 4, 2, 0, 1, 0, 2};
    vecs[19] = '{1, 4, 2, 0, 0, 0, 2};
    vecs[20] = '{1, 4, 2, 0, 0, 1, 2};
    vecs[21] = '{1, 4, 2, 0, 1, 0, 3};

    init_in = 1'b0;
    div_in  = DIV_WIDTH'(4);
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_state", 32'(state_o), 0);
    checkOutput("rst_dev_rst", 32'(dev_rst), 1);
    checkOutput("rst_clk_out", 32'(clk_out), 0);
    checkOutput("rst_stb", 32'(sample_stb), 0);
    checkOutput("rst_count", 32'(sample_count), 0);
    checkOutput("rst_running", 32'(running), 0);

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].init, vecs[i].div);
      stepCycle();
      checkOutput($sformatf("vec%0d_state", i), 32'(state_o), vecs[i].state);
      checkOutput($sformatf("vec%0d_dev_rst", i), 32'(dev_rst), vecs[i].devRst);
      checkOutput($sformatf("vec%0d_clk_out", i), 32'(clk_out), vecs[i].clkOut);
      checkOutput($sformatf("vec%0d_stb", i), 32'(sample_stb), vecs[i].stb);
      checkOutput($sformatf("vec%0d_count", i), 32'(sample_count), vecs[i].count);
    end

    // Asynchronous reset in the middle of RUN, between clock edges.
    #2;
    reset   = 1'b1;
    init_in = 1'b0;
    #1;
    checkOutput("async_rst_state", 32'(state_o), 0);
    checkOutput("async_rst_dev_rst", 32'(dev_rst), 1);
    checkOutput("async_rst_clk_out", 32'(clk_out), 0);
    checkOutput("async_rst_stb", 32'(sample_stb), 0);
    checkOutput("async_rst_count", 32'(sample_count), 0);
    checkOutput("async_rst_running", 32'(running), 0);
    modelReset();
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 4);
      stepCycle();
    end
    checkOutput("idle_after_rst", 32'(state_o), 0);

    // Clean stop with div 5, init dropped so RUN sees it at phase 1.
    minHigh   = 1000;
    applyStimulus(1, 5);
    waitState(2, 60, "div5_reach_run");
    n = 0;
    while (!((state_o == 2'd2) && ((mT % mDiv) == 0)) && (n < 20)) begin
      stepCycle();
      n++;
    end
    checkOutput("div5_phase0_found", 32'(n < 20), 1);
    applyStimulus(0, 5);
    stbInStop = 0;
    waitState(3, 5, "div5_enter_stopping");
    waitState(0, 20, "div5_back_idle");
    checkOutput("div5_stop_strobes", stbInStop, 1);
    checkOutput("div5_idle_clk_out", 32'(clk_out), 0);
    checkOutput("div5_idle_dev_rst", 32'(dev_rst), 1);
    checkOutput("div5_min_high_ge2", 32'(minHigh >= 2), 1);

    // Ratios below the minimum behave as div 2.
    for (int d = 0; d < 2; d++) begin
      applyStimulus(1, d);
      waitState(2, 40, "clamp_reach_run");
      lastStb = -1;
      for (int k = 0; k < 8; k++) begin
        stepCycle();
        if (sample_stb) begin
          if (lastStb >= 0) checkOutput($sformatf("clamp%0d_gap", d), cycleNo - lastStb, 2);
          lastStb = cycleNo;
        end
      end
      applyStimulus(0, d);
      waitState(0, 20, "clamp_back_idle");
    end

    // Abort three cycles into SETTLE, then restart with a new ratio.
    applyStimulus(1, 3);
    waitState(1, 10, "abort_reach_settle");
    stbCount = 0;
    stepCycle();
    stepCycle();
    applyStimulus(0, 3);
    waitState(0, 10, "abort_back_idle");
    repeat (5) stepCycle();
    checkOutput("abort_no_strobes", stbCount, 0);
    checkOutput("abort_count", 32'(sample_count), 0);
    applyStimulus(1, 6);
    waitState(1, 10, "restart_reach_settle");
    settleLen = 0;
    while ((state_o == 2'd1) && (settleLen < 50)) begin
      stepCycle();
      settleLen++;
    end
    checkOutput("restart_settle_len", settleLen, 12);
    checkOutput("restart_in_run", 32'(state_o), 2);
    applyStimulus(0, 6);
    waitState(0, 20, "restart_back_idle");

    // Counter saturation, then clear on the next start.
    applyStimulus(1, 2);
    waitState(2, 40, "sat_reach_run");
    repeat (45) stepCycle();
    checkOutput("sat_count_held", 32'(sample_count), CNT_MAX);
    applyStimulus(0, 2);
    waitState(0, 20, "sat_back_idle");
    checkOutput("sat_count_idle", 32'(sample_count), CNT_MAX);
    applyStimulus(1, 2);
    waitState(1, 10, "sat_restart_settle");
    checkOutput("sat_count_cleared", 32'(sample_count), 0);

    // Random init levels and ratios, model-checked every cycle.
    for (int i = 0; i < 250; i++) begin
      b    = ($urandom_range(0, 2) != 0) ? 1 : 0;
      hold = $urandom_range(1, 30);
      for (int k = 0; k < hold; k++) begin
        applyStimulus(b, $urandom_range(0, 9));
        stepCycle();
      end
    end

    applyStimulus(0, 4);
    waitState(0, 100, "final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
